// File: rtl/bcd_pkg.sv
// Shared BCD definitions: converter FSM states, default widths and a digit legality check.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_e;

    localparam int unsigned DIGITS_DEF = 6;
    localparam int unsigned BIN_W_DEF  = 20;

    function automatic logic bcd_digit_ok(input logic [3:0] nibble);
        return nibble <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_nib_adj.sv
// Reverse double-dabble nibble correction: subtract 3 from any nibble that is 8 or more.
module bcd_nib_adj (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    always_comb begin
        o_nib = i_nib;
        if (i_nib >= 4'd8) begin
            o_nib = i_nib - 4'd3;
        end
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one bit per clock,
// with start/busy/done handshake and illegal-digit flagging.
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEF,
    parameter int unsigned BIN_W  = BIN_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin,
    output logic                  err
);

    localparam int unsigned SW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(BIN_W + 1);

    bcd_state_e          r_state;
    logic [SW-1:0]       r_sreg;
    logic [BIN_W-1:0]    r_work;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [BIN_W-1:0]    r_bin;

    logic [SW+BIN_W-1:0] w_shift;
    logic [SW-1:0]       w_sreg_sh;
    logic [SW-1:0]       w_sreg_adj;
    logic [BIN_W-1:0]    w_work_sh;
    logic                w_legal;
    logic                w_last;

    // sreg and work shift as one register; sreg LSB feeds work MSB
    assign w_shift   = {r_sreg, r_work} >> 1;
    assign w_sreg_sh = w_shift[SW+BIN_W-1:BIN_W];
    assign w_work_sh = w_shift[BIN_W-1:0];
    assign w_last    = (r_cnt == CW'(BIN_W - 1));

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_nib_adj u_adj (
            .i_nib (w_sreg_sh[4*g +: 4]),
            .o_nib (w_sreg_adj[4*g +: 4])
        );
    end

    always_comb begin
        w_legal = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_ok(bcd[4*i +: 4])) begin
                w_legal = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_work  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_bin   <= '0;
        end else begin
            unique case (r_state)
                // DONE accepts a new start so back-to-back requests lose no cycle
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy <= 1'b1;
                        if (w_legal) begin
                            r_sreg  <= bcd;
                            r_work  <= '0;
                            r_cnt   <= '0;
                            r_err   <= 1'b0;
                            r_state <= SHIFT;
                        end else begin
                            r_err   <= 1'b1;
                            r_bin   <= '0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_sreg <= w_sreg_adj;
                    r_work <= w_work_sh;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_bin   <= w_work_sh;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bin  = r_bin;
    assign err  = r_err;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Scoreboard bench for bcd2bin_seq: the driver queues expected results, the monitor checks on done.
module tb_bcd2bin_seq;

    localparam int unsigned DIGITS = 6;
    localparam int unsigned BIN_W  = 20;

    logic                clk;
    logic                reset_n;
    logic                start;
    logic [4*DIGITS-1:0] bcd;
    logic                busy;
    logic                done;
    logic [BIN_W-1:0]    bin;
    logic                err;

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             err;
        int               issue;
        int               lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    bcd2bin_seq #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bcd     (bcd),
        .busy    (busy),
        .done    (done),
        .bin     (bin),
        .err     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 with bin=0x%0h, expected no pulse", bin);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("bin", 32'(bin), 32'(e.bin));
                chk("err", 32'(err), 32'(e.err));
                chk("done_edge", 32'(cyc - e.issue), 32'(e.lat));
                chk("busy_in_done", 32'(busy), 32'd1);
                if (!e.err) begin
                    chk("sreg_zero", 32'(dut.r_sreg), 32'd0);
                end
            end
        end
    end

    function automatic logic [BIN_W-1:0] bcd_val(input logic [4*DIGITS-1:0] v);
        int acc = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc = acc * 10 + int'(v[4*i +: 4]);
        end
        return BIN_W'(acc);
    endfunction

    task automatic push_exp(input logic [BIN_W-1:0] eb, input logic ee, input int issue);
        exp_t e;
        e.bin   = eb;
        e.err   = ee;
        e.issue = issue;
        e.lat   = ee ? 0 : int'(BIN_W);
        q.push_back(e);
    endtask

    // Waits for an accepting state (IDLE or DONE) and issues one start pulse.
    task automatic send(input logic [4*DIGITS-1:0] v, input logic [BIN_W-1:0] eb, input logic ee);
        int guard = 0;
        @(negedge clk);
        while (busy && !done && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got busy=1 for %0d cycles, expected accept", guard);
        end
        start = 1'b1;
        bcd   = v;
        push_exp(eb, ee, cyc + 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [4*DIGITS-1:0] v;
        logic [BIN_W-1:0]    eb;

        reset_n = 1'b0;
        start   = 1'b0;
        bcd     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bin", 32'(bin), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        send(24'h001234, 20'h004D2, 1'b0);
        send(24'h999999, 20'hF423F, 1'b0);
        send(24'h262143, 20'h3FFFF, 1'b0);
        send(24'h000000, 20'h00000, 1'b0);
        send(24'h000001, 20'h00001, 1'b0);
        send(24'h100000, 20'h186A0, 1'b0);
        drain();

        send(24'h00A500, 20'h00000, 1'b1);
        send(24'hF00000, 20'h00000, 1'b1);
        send(24'h000010, 20'h0000A, 1'b0);
        drain();

        // Start held high; bcd changes mid-conversion, second request taken at end of DONE
        @(negedge clk);
        start = 1'b1;
        bcd   = 24'h000042;
        push_exp(20'h0002A, 1'b0, cyc + 1);
        push_exp(20'h00309, 1'b0, cyc + 1 + int'(BIN_W) + 1);
        repeat (5) @(negedge clk);
        bcd = 24'h000777;
        repeat (17) @(negedge clk);
        start = 1'b0;
        drain();

        // Asynchronous reset in the middle of a conversion
        start = 1'b1;
        bcd   = 24'h123456;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bin", 32'(bin), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        send(24'h000555, 20'h0022B, 1'b0);
        drain();

        for (int n = 0; n < 200; n++) begin
            for (int d = 0; d < DIGITS; d++) begin
                v[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            eb = bcd_val(v);
            send(v, eb, 1'b0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
